// File: rtl/clock_time_keeper_if.sv
// Mode/pulse inputs and time/display outputs of the timekeeping datapath.
// The mode FSM side drives the master modport; the datapath uses the slave modport.
interface clock_time_keeper_if;
    logic [2:0] mode;
    logic       inc_hr;
    logic       inc_min;
    logic       alarm_en;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [4:0] disp_hours;
    logic [5:0] disp_minutes;
    logic       pm;
    logic       fmt_12h;
    logic       alarm_ring;

    modport master (
        output mode, inc_hr, inc_min, alarm_en,
        input  hours, minutes, seconds, disp_hours, disp_minutes, pm, fmt_12h, alarm_ring
    );

    modport slave (
        input  mode, inc_hr, inc_min, alarm_en,
        output hours, minutes, seconds, disp_hours, disp_minutes, pm, fmt_12h, alarm_ring
    );
endinterface

// File: rtl/clock_time_keeper.sv
// HH:MM:SS timekeeper with 1 Hz prescaler, time/alarm/format setting by mode,
// alarm ring control and 12/24-hour display conversion.
module clock_time_keeper #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    clock_time_keeper_if.slave  bus
);

    localparam int unsigned    PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRE_TC = PW'(CLK_HZ - 1);

    localparam logic [2:0] MODE_SET_TIME  = 3'b010;
    localparam logic [2:0] MODE_WAIT2     = 3'b011;
    localparam logic [2:0] MODE_SET_ALARM = 3'b100;
    localparam logic [2:0] MODE_WAIT3     = 3'b101;
    localparam logic [2:0] MODE_SET_FMT   = 3'b110;

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hr_q, hr_d;
    logic [5:0]    amin_q, amin_d;
    logic [4:0]    ahr_q, ahr_d;
    logic          fmt_q, fmt_d;
    logic          ring_q, ring_d;

    logic          hold;
    logic          tick;
    logic          sec_wrap;
    logic          min_wrap;
    logic [5:0]    nxt_sec;
    logic [5:0]    nxt_min;
    logic [4:0]    nxt_hr;
    logic          alarm_hit;
    logic [4:0]    src_hr;
    logic [5:0]    src_min;
    logic [4:0]    disp_hr;
    logic          disp_pm;

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    // Prescaler and the "next second" value of the time-of-day counter.
    always_comb begin
        hold     = (bus.mode == MODE_SET_TIME) || (bus.mode == MODE_WAIT2);
        tick     = !hold && (pre_q == PRE_TC);
        pre_d    = (hold || tick) ? '0 : pre_q + PW'(1);
        sec_wrap = (sec_q == 6'd59);
        min_wrap = (min_q == 6'd59);
        nxt_sec  = sec_wrap ? 6'd0 : sec_q + 6'd1;
        nxt_min  = sec_wrap ? inc_mod60(min_q) : min_q;
        nxt_hr   = (sec_wrap && min_wrap) ? inc_mod24(hr_q) : hr_q;
        alarm_hit = (nxt_hr == ahr_q) && (nxt_min == amin_q) && (nxt_sec == 6'd0);
    end

    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hr_d   = hr_q;
        amin_d = amin_q;
        ahr_d  = ahr_q;
        fmt_d  = fmt_q;

        case (bus.mode)
            MODE_SET_TIME: begin
                sec_d = 6'd0;
                if (bus.inc_min) min_d = inc_mod60(min_q);
                if (bus.inc_hr)  hr_d  = inc_mod24(hr_q);
            end
            MODE_WAIT2: begin
            end
            default: begin
                if (tick) begin
                    sec_d = nxt_sec;
                    min_d = nxt_min;
                    hr_d  = nxt_hr;
                end
            end
        endcase

        if (bus.mode == MODE_SET_ALARM) begin
            if (bus.inc_min) amin_d = inc_mod60(amin_q);
            if (bus.inc_hr)  ahr_d  = inc_mod24(ahr_q);
        end

        if ((bus.mode == MODE_SET_FMT) && (bus.inc_hr || bus.inc_min))
            fmt_d = ~fmt_q;
    end

    // A match lands on a seconds-wrap tick, so set must win over the auto-off.
    always_comb begin
        ring_d = ring_q;
        if (!bus.alarm_en)
            ring_d = 1'b0;
        else if (tick && alarm_hit)
            ring_d = 1'b1;
        else if (tick && sec_wrap)
            ring_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            sec_q  <= 6'd0;
            min_q  <= 6'd0;
            hr_q   <= 5'd0;
            amin_q <= 6'd0;
            ahr_q  <= 5'd0;
            fmt_q  <= 1'b0;
            ring_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
            amin_q <= amin_d;
            ahr_q  <= ahr_d;
            fmt_q  <= fmt_d;
            ring_q <= ring_d;
        end
    end

    always_comb begin
        if ((bus.mode == MODE_SET_ALARM) || (bus.mode == MODE_WAIT3)) begin
            src_hr  = ahr_q;
            src_min = amin_q;
        end else begin
            src_hr  = hr_q;
            src_min = min_q;
        end

        disp_hr = src_hr;
        disp_pm = 1'b0;
        if (fmt_q) begin
            if (src_hr == 5'd0) begin
                disp_hr = 5'd12;
            end else if (src_hr == 5'd12) begin
                disp_pm = 1'b1;
            end else if (src_hr > 5'd12) begin
                disp_hr = src_hr - 5'd12;
                disp_pm = 1'b1;
            end
        end
    end

    assign bus.hours        = hr_q;
    assign bus.minutes      = min_q;
    assign bus.seconds      = sec_q;
    assign bus.disp_hours   = disp_hr;
    assign bus.disp_minutes = src_min;
    assign bus.pm           = disp_pm;
    assign bus.fmt_12h      = fmt_q;
    assign bus.alarm_ring   = ring_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Scoreboard bench for clock_time_keeper at CLK_HZ=4: expectations are queued
// as stimulus is applied and compared against the outputs after the edges.
module tb_clock_time_keeper;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clock_time_keeper_if bus_if();

    clock_time_keeper #(.CLK_HZ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef enum int {K_HR, K_MIN, K_SEC, K_DH, K_DM, K_PM, K_FMT, K_RING} kind_e;
    typedef struct {
        kind_e kind;
        string tag;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_HR:    return {27'd0, bus_if.hours};
            K_MIN:   return {26'd0, bus_if.minutes};
            K_SEC:   return {26'd0, bus_if.seconds};
            K_DH:    return {27'd0, bus_if.disp_hours};
            K_DM:    return {26'd0, bus_if.disp_minutes};
            K_PM:    return {31'd0, bus_if.pm};
            K_FMT:   return {31'd0, bus_if.fmt_12h};
            default: return {31'd0, bus_if.alarm_ring};
        endcase
    endfunction

    task automatic expect_val(input kind_e k, input string tag, input int v);
        exp_t e;
        e.kind = k;
        e.tag  = tag;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic expect_time(input string tag, input int h, input int m, input int s);
        expect_val(K_HR,  {tag, "_hr"},  h);
        expect_val(K_MIN, {tag, "_min"}, m);
        expect_val(K_SEC, {tag, "_sec"}, s);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic h, input logic m);
        bus_if.inc_hr  = h;
        bus_if.inc_min = m;
        cyc(1);
        bus_if.inc_hr  = 1'b0;
        bus_if.inc_min = 1'b0;
        cyc(1);
    endtask

    task automatic pulses(input int n, input logic h, input logic m);
        for (int i = 0; i < n; i++) pulse(h, m);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.mode     = 3'($urandom_range(7));
            bus_if.inc_hr   = 1'($urandom_range(1));
            bus_if.inc_min  = 1'($urandom_range(1));
            bus_if.alarm_en = 1'($urandom_range(1));
            cyc(1);
        end
        expect_time(tag, 0, 0, 0);
        expect_val(K_DH,   {tag, "_dh"},   0);
        expect_val(K_DM,   {tag, "_dm"},   0);
        expect_val(K_PM,   {tag, "_pm"},   0);
        expect_val(K_FMT,  {tag, "_fmt"},  0);
        expect_val(K_RING, {tag, "_ring"}, 0);
        sb_drain();
        bus_if.mode     = 3'b000;
        bus_if.inc_hr   = 1'b0;
        bus_if.inc_min  = 1'b0;
        bus_if.alarm_en = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.mode     = 3'b000;
        bus_if.inc_hr   = 1'b0;
        bus_if.inc_min  = 1'b0;
        bus_if.alarm_en = 1'b0;

        // reset and first tick latency
        do_reset("rst0");
        expect_time("tick1", 0, 0, 1);
        cyc(4);
        sb_drain();
        expect_time("min1", 0, 1, 0);
        cyc(236);
        sb_drain();

        // set time
        do_reset("rst1");
        bus_if.mode = 3'b010;
        pulses(13, 1'b1, 1'b0);
        pulses(5, 1'b0, 1'b1);
        expect_time("set", 13, 5, 0);
        expect_val(K_DH, "set_dh24", 13);
        expect_val(K_PM, "set_pm24", 0);
        sb_drain();
        cyc(100);
        expect_time("hold", 13, 5, 0);
        sb_drain();
        pulses(60, 1'b0, 1'b1);
        expect_time("nocarry", 13, 5, 0);
        sb_drain();

        // format toggle, both pulses together
        bus_if.mode = 3'b110;
        pulse(1'b1, 1'b1);
        expect_val(K_FMT, "fmt_tog", 1);
        expect_val(K_DH,  "fmt_dh13", 1);
        expect_val(K_PM,  "fmt_pm13", 1);
        expect_val(K_DM,  "fmt_dm", 5);
        sb_drain();

        bus_if.mode = 3'b010;
        pulses(11, 1'b1, 1'b0);
        expect_val(K_HR, "h0", 0);
        expect_val(K_DH, "h0_dh", 12);
        expect_val(K_PM, "h0_pm", 0);
        sb_drain();
        pulses(12, 1'b1, 1'b0);
        expect_val(K_HR, "h12", 12);
        expect_val(K_DH, "h12_dh", 12);
        expect_val(K_PM, "h12_pm", 1);
        sb_drain();

        // rollover
        pulses(11, 1'b1, 1'b0);
        pulses(54, 1'b0, 1'b1);
        expect_time("pre_roll", 23, 59, 0);
        expect_val(K_DH, "h23_dh", 11);
        expect_val(K_PM, "h23_pm", 1);
        sb_drain();
        bus_if.mode = 3'b000;
        cyc(236);
        expect_time("t235959", 23, 59, 59);
        sb_drain();
        cyc(4);
        expect_time("roll", 0, 0, 0);
        expect_val(K_DH, "roll_dh", 12);
        expect_val(K_PM, "roll_pm", 0);
        sb_drain();

        // alarm set while time keeps running
        bus_if.mode = 3'b100;
        pulses(6, 1'b1, 1'b0);
        pulses(30, 1'b0, 1'b1);
        expect_time("aset_time", 0, 0, 18);
        expect_val(K_DH, "aset_dh", 6);
        expect_val(K_DM, "aset_dm", 30);
        expect_val(K_PM, "aset_pm", 0);
        sb_drain();

        bus_if.mode = 3'b010;
        pulses(6, 1'b1, 1'b0);
        pulses(29, 1'b0, 1'b1);
        bus_if.mode = 3'b000;
        cyc(232);
        expect_time("a_0629_58", 6, 29, 58);
        sb_drain();
        bus_if.alarm_en = 1'b1;
        cyc(4);
        expect_time("a_0629_59", 6, 29, 59);
        expect_val(K_RING, "ring_pre", 0);
        sb_drain();
        cyc(3);
        expect_val(K_RING, "ring_pre2", 0);
        sb_drain();
        cyc(1);
        expect_time("a_0630", 6, 30, 0);
        expect_val(K_RING, "ring_rise", 1);
        sb_drain();
        cyc(236);
        expect_time("a_0630_59", 6, 30, 59);
        expect_val(K_RING, "ring_hold", 1);
        sb_drain();
        cyc(3);
        expect_val(K_RING, "ring_hold2", 1);
        sb_drain();
        cyc(1);
        expect_time("a_0631", 6, 31, 0);
        expect_val(K_RING, "ring_auto_off", 0);
        sb_drain();

        // ring again, edit alarm while ringing, then drop alarm_en
        bus_if.mode = 3'b010;
        pulses(58, 1'b0, 1'b1);
        bus_if.mode = 3'b000;
        cyc(232);
        cyc(8);
        expect_time("b_0630", 6, 30, 0);
        expect_val(K_RING, "ring2_rise", 1);
        sb_drain();
        bus_if.mode = 3'b100;
        pulse(1'b0, 1'b1);
        expect_val(K_RING, "ring_edit", 1);
        expect_val(K_DM,   "edit_dm", 31);
        expect_val(K_DH,   "edit_dh", 6);
        sb_drain();
        bus_if.mode = 3'b000;
        cyc(38);
        expect_time("b_063010", 6, 30, 10);
        expect_val(K_RING, "ring2_hold", 1);
        sb_drain();
        bus_if.alarm_en = 1'b0;
        cyc(1);
        expect_val(K_RING, "ring_en_off", 0);
        expect_time("b_after", 6, 30, 10);
        sb_drain();

        // pulses ignored outside set modes
        do_reset("rst2");
        bus_if.mode = 3'b000;
        pulse(1'b1, 1'b1);
        bus_if.mode = 3'b001;
        pulse(1'b1, 1'b1);
        bus_if.mode = 3'b101;
        pulse(1'b1, 1'b1);
        bus_if.mode = 3'b111;
        pulse(1'b1, 1'b1);
        expect_time("ign_run", 0, 0, 2);
        expect_val(K_FMT, "ign_fmt", 0);
        sb_drain();
        bus_if.mode = 3'b011;
        pulse(1'b1, 1'b1);
        expect_time("ign_wait2", 0, 0, 2);
        expect_val(K_FMT, "ign_fmt2", 0);
        sb_drain();
        bus_if.mode = 3'b101;
        #1;
        expect_val(K_DH, "ign_alarm_h", 0);
        expect_val(K_DM, "ign_alarm_m", 0);
        sb_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
